// File: rtl/stream_mux_arb.sv
// stream_mux_arb: registered CH-to-1 stream multiplexer with valid/ready
// handshaking. The winning channel is chosen either by an external fixed
// select (mode=0) or by a round-robin arbiter (mode=1). The winning word is
// moved into a single-entry output register.
module stream_mux_arb #(
   parameter  int N    = 32,
   parameter  int CH   = 4,
   localparam int SELW = $clog2(CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH*N-1:0]   in_data,
   input  logic [CH-1:0]     in_valid,
   output logic [CH-1:0]     in_ready,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   output logic [N-1:0]      out_data,
   output logic              out_valid,
   output logic [SELW-1:0]   out_ch,
   input  logic              out_ready
);

   localparam int            CHP  = 1 << SELW;
   localparam logic [SELW:0] CH_W = (SELW+1)'(CH);

   // Valid vector padded to a power of two, so a select that names a
   // non-existent channel reads as "not valid" instead of out of range.
   logic [CHP-1:0]  valid_ext;

   logic [SELW-1:0] rr_ptr;
   logic [SELW-1:0] rr_idx;
   logic            rr_found;
   logic [SELW:0]   cand;

   logic            grant_vld;
   logic [SELW-1:0] grant_idx;
   logic [SELW-1:0] rr_next;
   logic [N-1:0]    data_sel;
   logic            can_load;

   logic [N-1:0]    data_p1;
   logic [SELW-1:0] ch_p1;
   logic            vld_p1;

   assign valid_ext = CHP'(in_valid);
   assign can_load  = !vld_p1 || out_ready;
   assign rr_next   = (grant_idx == SELW'(CH - 1)) ? '0 : grant_idx + SELW'(1);

   assign out_data  = data_p1;
   assign out_ch    = ch_p1;
   assign out_valid = vld_p1;

   // Round-robin search: first valid channel at or after rr_ptr, modulo CH.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = '0;
      for (int i = 0; i < CH; i++) begin
         cand = {1'b0, rr_ptr} + (SELW+1)'(i);
         if (cand >= CH_W) begin
            cand = cand - CH_W;
         end
         if (!rr_found && valid_ext[cand[SELW-1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = cand[SELW-1:0];
         end
      end
   end

   // Grant selection: fixed select or round-robin winner.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      if (mode) begin
         grant_vld = rr_found;
         grant_idx = rr_idx;
      end else begin
         grant_vld = valid_ext[sel];
         grant_idx = sel;
      end
   end

   // One-hot ready towards the granted channel, forced low during reset.
   always_comb begin
      in_ready = '0;
      if (rst_n && can_load && grant_vld) begin
         in_ready[grant_idx] = 1'b1;
      end
   end

   // Data mux for the granted channel; feeds only the output register.
   always_comb begin
      data_sel = in_data[0 +: N];
      for (int k = 0; k < CH; k++) begin
         if (grant_idx == SELW'(k)) begin
            data_sel = in_data[k*N +: N];
         end
      end
   end

   // ---- stage p1: output register and round-robin pointer ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         ch_p1   <= '0;
         rr_ptr  <= '0;
      end else if (can_load) begin
         if (grant_vld) begin
            vld_p1  <= 1'b1;
            data_p1 <= data_sel;
            ch_p1   <= grant_idx;
            if (mode) begin
               rr_ptr <= rr_next;
            end
         end else begin
            vld_p1 <= 1'b0;
         end
      end
   end

endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised, registered CH-to-1 stream multiplexer with valid/ready handshaking. It is the successor to the plain combinational 2:1/4:1 select muxes. Each cycle it picks one requesting input channel, either by an external fixed select or by a round-robin arbiter, and moves that channel's word into a single output register. It sits between parallel producer lanes (e.g. per-sample datapath units) and a single downstream consumer that can stall.

## Interface
- N, 32, data width per channel in bits.
- CH, 4, number of input channels; legal range 2..16.
- SELW, $clog2(CH), select/channel-index width; derived, not overridden.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  CH*N  channel k occupies bits [k*N+N-1 : k*N].
- in_valid  input  CH  per-channel valid.
- in_ready  output  CH  per-channel ready; one-hot or zero.
- mode  input  1  0 = fixed select, 1 = round-robin arbitration.
- sel  input  SELW  channel to pass when mode=0.
- out_data  output  N  registered data.
- out_valid  output  1  registered valid.
- out_ch  output  SELW  index of the channel that produced out_data.
- out_ready  input  1  downstream ready.

## Operation
- Output register is one entry: {out_data, out_ch, out_valid}.
- Output transfer occurs when out_valid && out_ready.
- Register can accept when `can_load = !out_valid || out_ready`.
- Grant, computed combinationally each cycle:
  - mode=0: candidate is sel. If sel >= CH, there is no candidate. Grant is asserted only if in_valid[sel].
  - mode=1: search starts at pointer rr_ptr and scans rr_ptr, rr_ptr+1, … modulo CH. The first channel with in_valid=1 is the candidate.
- in_ready[g] = can_load && grant to g. All other in_ready bits are 0. At most one bit is ever set.
- Input transfer on channel g occurs when in_valid[g] && in_ready[g]. On that edge:
  - out_data ← channel g data.
  - out_ch ← g.
  - out_valid ← 1.
- If can_load is true and there is no grant, out_valid ← 0 and out_data/out_ch hold their values.
- rr_ptr handling:
  - Updates only on an input transfer while mode=1: rr_ptr ← (g+1) mod CH. Wrap goes from CH-1 to 0.
  - Holds in mode=0.
  - Holds on cycles with no transfer, including stalls.
- Mode or sel may change on any cycle. The change affects only the grant of that same cycle. A word already in the output register is never altered.
- in_data of non-granted channels is ignored.
- No data loss or duplication: every input transfer produces exactly one output transfer, in order.

## Timing
- Latency is 1 cycle: a word accepted at edge t is presented on out_data after edge t. It can leave at edge t+1 if out_ready=1.
- Throughput is one word per cycle while out_ready stays high.
- in_ready depends combinationally on out_ready, out_valid, in_valid, mode, sel and rr_ptr. There is no combinational path from in_data to any output.
- Reset (rst_n=0, asynchronous, applies immediately regardless of clk):
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - in_ready=0 for all channels, because in_ready is gated by rst_n.
- Reset mid-operation: any word held in the output register is discarded. The first grant after release starts from channel 0 in mode=1.
- Simultaneous output drain and input accept on the same edge: the new word replaces the old one, out_valid stays 1 and there is no bubble.
- Stall (out_valid=1, out_ready=0):
  - All in_ready are 0.
  - Output register holds.
  - rr_ptr holds.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1. Required: out_valid, out_data, out_ch drop to 0 without waiting for a clk edge, and in_ready=0. After release with mode=1 and all in_valid=1, first out_ch=0.
- Fixed select, N=32, CH=4: mode=0, sel=2, in_valid=4'b1111, channel 2 data=0xA5A5_0002, out_ready=1. Required: in_ready=4'b0100 and next cycle out_data=0xA5A5_0002, out_ch=2. Then set sel=2 with in_valid[2]=0: in_ready=0 and out_valid falls to 0.
- Round-robin fairness: mode=1, all in_valid held at 1, out_ready=1 for 8 cycles. Required: out_ch sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
- Skip and wrap: mode=1, rr_ptr=3, in_valid=4'b0010. Required: grant ch1 and rr_ptr becomes 2. Next, with in_valid=4'b1001: grant ch3, then wrap to grant ch0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while inputs are valid. Required: out_data/out_ch stable, in_ready=0, rr_ptr unchanged. When out_ready=1 the next word loads on the same edge as the drain.
- Scoreboard: random in_valid, out_ready and mode over 10k cycles with CH=3 (non-power-of-two) and N=8. Required: every accepted word appears exactly once at the output, in order, with the correct out_ch, and in_ready is never multi-hot.
